visitor_dir_counter: RTL and testbench
======================================

Name: visitor_dir_counter

Overview:
- Bidirectional visitor-counter core. Consumes two raw beam-break sensors at the doorway (sens_a outside, sens_b inside), works out the crossing direction, and keeps a saturating occupancy count.
- Binary count is updated by the team's half-adder-chain incrementer/decrementer datapath.
- Count is exported as binary and as two BCD digits for the downstream 7-segment display stage.

Parameters:
- MAX_COUNT, 99, saturation ceiling for occupancy (1..99).
- CNT_W, 7, binary count width (must hold MAX_COUNT).
- DB_CYCLES, 4, consecutive stable samples required to accept a sensor level change (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- sens_a, input, 1, raw outer sensor, 1 = beam broken, asynchronous to clk.
- sens_b, input, 1, raw inner sensor, 1 = beam broken, asynchronous to clk.
- count, output, CNT_W, current occupancy, binary.
- bcd_tens, output, 4, tens digit of count.
- bcd_ones, output, 4, ones digit of count.
- entry_pulse, output, 1, one-cycle strobe on each accepted entry.
- exit_pulse, output, 1, one-cycle strobe on each accepted exit.
- full, output, 1, count == MAX_COUNT.
- empty, output, 1, count == 0.
- reject_pulse, output, 1, one-cycle strobe when an entry hits full or an exit hits empty.

Behaviour:
- Reset (async assert, sync release):
  - count, bcd_tens, bcd_ones = 0; empty = 1; full = 0.
  - All pulses = 0; FSM = IDLE; synchronisers and debouncers cleared to 0.
- Input conditioning, per sensor:
  - 2-flop synchroniser, then debouncer.
  - The debounced level changes only after DB_CYCLES consecutive samples that differ from the current level.
  - Latency from raw edge to debounced edge = 2 + DB_CYCLES cycles.
- Direction FSM on debounced levels (a, b):
  - IDLE: a & !b -> A1. !a & b -> B1. a & b -> WAIT_CLR.
  - A1: a & b -> AB_IN. !a & !b -> IDLE (aborted, no event).
  - AB_IN: !a & b -> B_LAST. !a & !b -> commit entry, IDLE.
  - B_LAST: !a & !b -> commit entry, IDLE. a -> AB_IN (person backed up).
  - B1 / AB_OUT / A_LAST: mirror of A1 / AB_IN / B_LAST with a and b swapped; commit = exit.
  - WAIT_CLR: !a & !b -> IDLE, no event.
- Commit rules:
  - A commit is evaluated in the cycle the FSM returns to IDLE.
  - At most one commit per cycle.
  - Entry and exit can never be committed together.
- Count update happens on the clock edge following the commit:
  - Entry with count < MAX_COUNT: count + 1, entry_pulse = 1 for that cycle.
  - Entry with count == MAX_COUNT: count held, reject_pulse = 1, entry_pulse = 0.
  - Exit with count > 0: count - 1, exit_pulse = 1.
  - Exit with count == 0: count held, reject_pulse = 1, exit_pulse = 0.
- BCD digits are kept as a parallel counter and update on the same edge as count (no extra latency):
  - Ones wraps 9 -> 0 with tens + 1 on increment.
  - Ones wraps 0 -> 9 with tens - 1 on decrement.
- full and empty are combinational decodes of the registered count.
- Reset asserted mid-crossing: everything returns to reset values immediately. A crossing in progress is discarded. After release, sensors already high put the FSM in A1, B1 or WAIT_CLR per the IDLE rules.

Decomposition:
- Shared package visitor_pkg holds:
  - FSM state enum (IDLE, A1, AB_IN, B_LAST, B1, AB_OUT, A_LAST, WAIT_CLR).
  - BCD digit typedef (4 bits).
  - Localparam BCD_MAX = 9.
- One sub-module, sensor_conditioner: synchroniser plus DB_CYCLES debouncer. Instantiated twice (sens_a, sens_b).
- Incrementer/decrementer uses the existing half_adder cells in a ripple chain.

Test Plan:
- Reset: hold rst_n=0 with sensors toggling -> count=0, bcd=0/0, empty=1, no pulses. Release -> still 0.
- Entry, DB_CYCLES=4: sequence a=1; a=b=1; a=0,b=1; all 0, each level held 10 cycles -> count=1, bcd_ones=1, exactly one entry_pulse, arriving 7 cycles after the final release edge.
- Exit from 12: mirrored sequence starting at b -> count=11, exit_pulse once. Then two more exits and a 10->9 case -> bcd 1/0 goes to 0/9.
- Saturation: preload 99 via 99 entries, then one entry -> count stays 99, full=1, reject_pulse=1, no entry_pulse. Exit at count 0 -> reject_pulse, count 0.
- Abort/backtrack:
  - a=1 then a=0 (no b) -> no event.
  - a; ab; b; ab; b; 0 -> exactly one entry.
  - Both sensors together from idle then both clear -> no event.
  - 2-cycle glitch on sens_a -> no FSM change.
- Reset mid-crossing: assert rst_n=0 while in AB_IN -> count=0 asynchronously. After release with sensors low -> no stale commit.

Source files
------------

// File: rtl/visitor_pkg.sv
// Shared types for the visitor direction counter: FSM states and BCD digit type.
package visitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A1,
        AB_IN,
        B_LAST,
        B1,
        AB_OUT,
        A_LAST,
        WAIT_CLR
    } dir_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell used to build the ripple incrementer chain.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/sensor_conditioner.sv
// Two-flop synchroniser followed by a run-length debouncer for one beam sensor.
// The debounced level flips only after DB_CYCLES consecutive synchronised
// samples disagree with it, giving 2 + DB_CYCLES cycles from raw to level.
module sensor_conditioner
    import visitor_pkg::*;
#(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    // Bring the asynchronous raw sensor into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreeing samples; accept the new level on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level   <= 1'b0;
            run_cnt <= '0;
        end else if (sync2 == level) begin
            run_cnt <= '0;
        end else if (run_cnt == CW'(DB_CYCLES - 1)) begin
            level   <= sync2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/visitor_dir_counter.sv
// Bidirectional visitor counter: conditions two doorway sensors, decodes the
// crossing direction and maintains a saturating binary and BCD occupancy count.
module visitor_dir_counter
    import visitor_pkg::*;
#(
    parameter int MAX_COUNT = 99,
    parameter int CNT_W     = 7,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sens_a,
    input  logic             sens_b,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic             full,
    output logic             empty,
    output logic             reject_pulse
);

    logic a_lvl;
    logic b_lvl;

    dir_state_t state;
    dir_state_t next_state;
    logic       commit_entry;
    logic       commit_exit;

    logic [CNT_W-1:0] operand;
    logic [CNT_W-1:0] chain_sum;
    logic [CNT_W-1:0] chain_carry;
    logic [CNT_W-1:0] next_bin;

    bcd_digit_t tens_q;
    bcd_digit_t ones_q;
    bcd_digit_t tens_next;
    bcd_digit_t ones_next;

    sensor_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sens_a),
        .level (a_lvl)
    );

    sensor_conditioner #(.DB_CYCLES(DB_CYCLES)) u_cond_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sens_b),
        .level (b_lvl)
    );

    // Direction FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a commit fires in the cycle the FSM heads back to IDLE.
    always_comb begin
        next_state   = state;
        commit_entry = 1'b0;
        commit_exit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (a_lvl && !b_lvl)      next_state = A1;
                else if (!a_lvl && b_lvl) next_state = B1;
                else if (a_lvl && b_lvl)  next_state = WAIT_CLR;
            end
            A1: begin
                if (a_lvl && b_lvl)        next_state = AB_IN;
                else if (!a_lvl && !b_lvl) next_state = IDLE;
            end
            AB_IN: begin
                if (!a_lvl && b_lvl) begin
                    next_state = B_LAST;
                end else if (!a_lvl && !b_lvl) begin
                    next_state   = IDLE;
                    commit_entry = 1'b1;
                end
            end
            B_LAST: begin
                if (a_lvl) begin
                    next_state = AB_IN;
                end else if (!b_lvl) begin
                    next_state   = IDLE;
                    commit_entry = 1'b1;
                end
            end
            B1: begin
                if (a_lvl && b_lvl)        next_state = AB_OUT;
                else if (!a_lvl && !b_lvl) next_state = IDLE;
            end
            AB_OUT: begin
                if (a_lvl && !b_lvl) begin
                    next_state = A_LAST;
                end else if (!a_lvl && !b_lvl) begin
                    next_state  = IDLE;
                    commit_exit = 1'b1;
                end
            end
            A_LAST: begin
                if (b_lvl) begin
                    next_state = AB_OUT;
                end else if (!a_lvl) begin
                    next_state  = IDLE;
                    commit_exit = 1'b1;
                end
            end
            WAIT_CLR: begin
                if (!a_lvl && !b_lvl) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Shared half-adder chain: x+1 directly, x-1 computed as ~(~x + 1).
    always_comb begin
        operand  = commit_exit ? ~count : count;
        next_bin = commit_exit ? ~chain_sum : chain_sum;
    end

    assign chain_carry[0] = 1'b1;

    for (genvar gi = 0; gi < CNT_W - 1; gi++) begin : g_inc_chain
        half_adder u_ha (
            .a     (operand[gi]),
            .b     (chain_carry[gi]),
            .sum   (chain_sum[gi]),
            .carry (chain_carry[gi+1])
        );
    end

    assign chain_sum[CNT_W-1] = operand[CNT_W-1] ^ chain_carry[CNT_W-1];

    // Parallel BCD step so the digits move on the same edge as the binary count.
    always_comb begin
        tens_next = tens_q;
        ones_next = ones_q;
        if (commit_exit) begin
            if (ones_q == 4'd0) begin
                ones_next = BCD_MAX;
                tens_next = tens_q - 4'd1;
            end else begin
                ones_next = ones_q - 4'd1;
            end
        end else begin
            if (ones_q == BCD_MAX) begin
                ones_next = 4'd0;
                tens_next = tens_q + 4'd1;
            end else begin
                ones_next = ones_q + 4'd1;
            end
        end
    end

    // Apply a committed crossing to the count, or flag it when saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            tens_q       <= '0;
            ones_q       <= '0;
            entry_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
        end else begin
            entry_pulse  <= 1'b0;
            exit_pulse   <= 1'b0;
            reject_pulse <= 1'b0;
            if (commit_entry) begin
                if (!full) begin
                    count       <= next_bin;
                    tens_q      <= tens_next;
                    ones_q      <= ones_next;
                    entry_pulse <= 1'b1;
                end else begin
                    reject_pulse <= 1'b1;
                end
            end else if (commit_exit) begin
                if (!empty) begin
                    count      <= next_bin;
                    tens_q     <= tens_next;
                    ones_q     <= ones_next;
                    exit_pulse <= 1'b1;
                end else begin
                    reject_pulse <= 1'b1;
                end
            end
        end
    end

    assign full     = (count == CNT_W'(MAX_COUNT));
    assign empty    = (count == '0);
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;

endmodule

// File: tb/tb_visitor_dir_counter.sv
// Scoreboard bench for visitor_dir_counter: crossings are issued as whole
// gestures, an occupancy model predicts each strobe, and a monitor checks them.
module tb_visitor_dir_counter;

    localparam int MAX_COUNT = 99;
    localparam int CNT_W     = 7;
    localparam int DB_CYCLES = 4;
    localparam int LATENCY   = 2 + DB_CYCLES + 1;

    localparam int EV_ENTRY  = 0;
    localparam int EV_EXIT   = 1;
    localparam int EV_REJECT = 2;

    localparam int K_ENTRY    = 0;
    localparam int K_EXIT     = 1;
    localparam int K_ABORT_A  = 2;
    localparam int K_ABORT_B  = 3;
    localparam int K_BOTH     = 4;
    localparam int K_GLITCH   = 5;
    localparam int K_BACK_IN  = 6;
    localparam int K_BACK_OUT = 7;

    typedef struct {
        int kind;
        int count;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             sens_a;
    logic             sens_b;
    logic [CNT_W-1:0] count;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic             entry_pulse;
    logic             exit_pulse;
    logic             full;
    logic             empty;
    logic             reject_pulse;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   model_occ = 0;
    int   mon_count = 0;
    int   cyc = 0;
    int   release_cyc = 0;
    int   last_pulse_cyc = -1;
    bit   done = 0;

    visitor_dir_counter #(
        .MAX_COUNT (MAX_COUNT),
        .CNT_W     (CNT_W),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sens_a       (sens_a),
        .sens_b       (sens_b),
        .count        (count),
        .bcd_tens     (bcd_tens),
        .bcd_ones     (bcd_ones),
        .entry_pulse  (entry_pulse),
        .exit_pulse   (exit_pulse),
        .full         (full),
        .empty        (empty),
        .reject_pulse (reject_pulse)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time strobes against sensor edges.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Occupancy model: a completed walk-through either moves the count or is rejected.
    task automatic modelCrossing(input bit inward);
        exp_t e;
        if (inward) begin
            if (model_occ < MAX_COUNT) begin
                model_occ++;
                e.kind = EV_ENTRY;
            end else begin
                e.kind = EV_REJECT;
            end
        end else begin
            if (model_occ > 0) begin
                model_occ--;
                e.kind = EV_EXIT;
            end else begin
                e.kind = EV_REJECT;
            end
        end
        e.count = model_occ;
        sb.push_back(e);
    endtask

    task automatic drivePhase(input logic a, input logic b, input int cycles);
        @(negedge clk);
        sens_a      = a;
        sens_b      = b;
        release_cyc = cyc;
        repeat (cycles) @(posedge clk);
    endtask

    // Issue one doorway gesture and record what it should do to occupancy.
    task automatic applyStimulus(input int kind, input bit randomize_hold);
        logic [1:0] seq[$];
        int hold;
        case (kind)
            K_ENTRY: begin
                seq = '{2'b10, 2'b11};
                if (!randomize_hold || $urandom_range(1, 0) == 1) seq.push_back(2'b01);
                seq.push_back(2'b00);
                modelCrossing(1'b1);
            end
            K_EXIT: begin
                seq = '{2'b01, 2'b11};
                if (!randomize_hold || $urandom_range(1, 0) == 1) seq.push_back(2'b10);
                seq.push_back(2'b00);
                modelCrossing(1'b0);
            end
            K_ABORT_A:  seq = '{2'b10, 2'b00};
            K_ABORT_B:  seq = '{2'b01, 2'b00};
            K_BOTH:     seq = '{2'b11, 2'b00};
            K_BACK_IN: begin
                seq = '{2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
                modelCrossing(1'b1);
            end
            K_BACK_OUT: begin
                seq = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
                modelCrossing(1'b0);
            end
            default: begin
                drivePhase(1'b1, 1'b0, 2);
                seq = '{2'b00};
            end
        endcase
        foreach (seq[i]) begin
            hold = randomize_hold ? int'($urandom_range(12, 6)) : 10;
            if (i == seq.size() - 1) hold = 10;
            drivePhase(seq[i][1], seq[i][0], hold);
        end
    endtask

    // Monitor: pop an expectation whenever a strobe appears and track the count.
    always @(negedge clk) begin
        int   npulse;
        int   got_kind;
        exp_t e;
        if (!done) begin
            if (!rst_n) begin
                mon_count = 0;
                checkOutput("reset_pulses", int'(entry_pulse) + int'(exit_pulse) + int'(reject_pulse), 0);
            end else begin
                npulse = int'(entry_pulse) + int'(exit_pulse) + int'(reject_pulse);
                if (npulse > 0) begin
                    if (npulse > 1) checkOutput("pulse_onehot", npulse, 1);
                    got_kind = entry_pulse ? EV_ENTRY : (exit_pulse ? EV_EXIT : EV_REJECT);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", got_kind, cyc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("pulse_kind", got_kind, e.kind);
                        checkOutput("pulse_count", int'(count), e.count);
                        mon_count      = e.count;
                        last_pulse_cyc = cyc;
                    end
                end
            end
            checkOutput("count", int'(count), mon_count);
            checkOutput("bcd_tens", int'(bcd_tens), mon_count / 10);
            checkOutput("bcd_ones", int'(bcd_ones), mon_count % 10);
            checkOutput("full", int'(full), (mon_count == MAX_COUNT) ? 1 : 0);
            checkOutput("empty", int'(empty), (mon_count == 0) ? 1 : 0);
        end
    end

    // Main sequence: directed corner cases, then a randomized walk.
    initial begin
        int k;
        int waited;
        rst_n  = 1'b0;
        sens_a = 1'b0;
        sens_b = 1'b0;

        repeat (10) begin
            @(negedge clk);
            sens_a = 1'($urandom_range(1, 0));
            sens_b = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        sens_a = 1'b0;
        sens_b = 1'b0;
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_empty", int'(empty), 1);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("post_release_count", int'(count), 0);

        $display("[TB] directed entry and latency");
        applyStimulus(K_ENTRY, 1'b0);
        checkOutput("entry_latency", last_pulse_cyc - release_cyc, LATENCY);
        checkOutput("entry_count", int'(count), 1);

        $display("[TB] exit to empty and reject at empty");
        applyStimulus(K_EXIT, 1'b0);
        applyStimulus(K_EXIT, 1'b0);
        checkOutput("empty_after_reject", int'(count), 0);

        $display("[TB] aborts, glitch and backtracking");
        applyStimulus(K_ABORT_A, 1'b0);
        applyStimulus(K_ABORT_B, 1'b0);
        applyStimulus(K_BOTH, 1'b0);
        applyStimulus(K_GLITCH, 1'b0);
        applyStimulus(K_BACK_IN, 1'b0);
        applyStimulus(K_BACK_OUT, 1'b0);

        $display("[TB] up to 12, down through 10 to 9");
        repeat (12) applyStimulus(K_ENTRY, 1'b1);
        repeat (3) applyStimulus(K_EXIT, 1'b1);
        @(negedge clk);
        checkOutput("bcd_nine_tens", int'(bcd_tens), 0);
        checkOutput("bcd_nine_ones", int'(bcd_ones), 9);

        $display("[TB] saturate at ceiling");
        while (model_occ < MAX_COUNT) applyStimulus(K_ENTRY, 1'b1);
        applyStimulus(K_ENTRY, 1'b1);
        @(negedge clk);
        checkOutput("sat_count", int'(count), MAX_COUNT);
        checkOutput("sat_full", int'(full), 1);

        $display("[TB] randomized crossings");
        repeat (120) begin
            k = int'($urandom_range(11, 0));
            if (k >= 8) k = (k % 2 == 0) ? K_ENTRY : K_EXIT;
            applyStimulus(k, 1'b1);
        end

        $display("[TB] reset in the middle of a crossing");
        repeat (3) applyStimulus(K_ENTRY, 1'b1);
        drivePhase(1'b1, 1'b0, 8);
        drivePhase(1'b1, 1'b1, 8);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_count", int'(count), 0);
        checkOutput("async_reset_empty", int'(empty), 1);
        model_occ = 0;
        sens_a    = 1'b0;
        sens_b    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        applyStimulus(K_ENTRY, 1'b0);
        @(negedge clk);
        checkOutput("after_reset_entry", int'(count), 1);

        waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);

        done = 1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
